signed_or_unsigned_div: RTL

- Iterative divider; the inverse operation of the team's signed/unsigned multiplier.
- Computes quotient and remainder of two n-bit operands, interpreted as signed or unsigned per request.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock.
- Valid/ready handshakes on both input and output, so it drops into the sequential arithmetic pipelines without further glue.

---
 rtl/signed_or_unsigned_div.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/signed_or_unsigned_div.sv
// Iterative restoring divider for signed or unsigned n-bit operands.
// One quotient bit per clock, valid/ready handshakes on request and result.
module signed_or_unsigned_div #(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  output logic         arg_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         signed_div,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CntW = (n > 2) ? $clog2(n) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [n-1:0]    quo_q, quo_d;
  logic [n-1:0]    rem_q, rem_d;
  logic [n-1:0]    div_q, div_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            zero_q, zero_d;
  logic [n-1:0]    quotient_q, quotient_d;
  logic [n-1:0]    remainder_q, remainder_d;
  logic            dbz_q, dbz_d;

  logic            a_neg, b_neg;
  logic [n-1:0]    a_mag, b_mag;
  logic [n:0]      shifted, diff;

  assign a_neg = signed_div & a[n-1];
  assign b_neg = signed_div & b[n-1];
  // The magnitude of the most-negative value, 2^(n-1), still fits in n unsigned bits.
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Dividend bits stream out of quo_q's MSB while quotient bits enter its LSB.
  assign shifted = {rem_q, quo_q[n-1]};
  assign diff    = shifted - {1'b0, div_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    div_d       = div_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (arg_vld) begin
          zero_d  = (b == '0);
          // On divide-by-zero keep the raw dividend; it becomes the remainder.
          quo_d   = (b == '0) ? a : a_mag;
          rem_d   = '0;
          div_d   = b_mag;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = (b == '0) ? StFix : StCalc;
        end
      end
      StCalc: begin
        if (!diff[n]) begin
          rem_d = diff[n-1:0];
          quo_d = {quo_q[n-2:0], 1'b1};
        end else begin
          rem_d = shifted[n-1:0];
          quo_d = {quo_q[n-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(n - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
          dbz_d       = 1'b1;
        end else begin
          // Negating a zero magnitude yields zero, so no separate nonzero test is needed.
          quotient_d  = q_neg_q ? -quo_q : quo_q;
          remainder_d = r_neg_q ? -rem_q : rem_q;
          dbz_d       = 1'b0;
        end
        state_d = StDone;
      end
      StDone: begin
        if (res_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign arg_rdy     = (state_q == StIdle);
  assign res_vld     = (state_q == StDone);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
